// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port to one-port memory arbiter.
package lc3b_types;

  localparam int unsigned WordWidth = 16;
  localparam int unsigned MaskWidth = WordWidth / 8;

  typedef logic [WordWidth-1:0] lc3b_word;
  typedef logic [MaskWidth-1:0] lc3b_mem_wmask;

  // Arbiter FSM states, exported so benches can name them.
  typedef enum logic [1:0] {
    StIdle,
    StServeA,
    StServeB
  } arb_state_t;

  // Which requester won the most recent grant.
  typedef enum logic {
    GrantA,
    GrantB
  } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// One memory request/response port. The requester side uses the master
// modport, the responder side uses the slave modport.
interface mem_arbiter_if #(
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned DataWidth = 16
) ();

  localparam int unsigned MaskWidth = DataWidth / 8;

  logic                 read;
  logic                 write;
  logic [MaskWidth-1:0] wmask;
  logic [AddrWidth-1:0] address;
  logic [DataWidth-1:0] wdata;
  logic                 resp;
  logic [DataWidth-1:0] rdata;

  modport master (
    output read,
    output write,
    output wmask,
    output address,
    output wdata,
    input  resp,
    input  rdata
  );

  modport slave (
    input  read,
    input  write,
    input  wmask,
    input  address,
    input  wdata,
    output resp,
    output rdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction (A) and data (B) ports onto one memory port.
// A granted request is latched and replayed downstream until pmem resp; the
// response is steered back to the owner. Contention alternates round-robin.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned DataWidth = 16
) (
  input logic            clk,
  input logic            reset,
  mem_arbiter_if.slave   port_a_io,
  mem_arbiter_if.slave   port_b_io,
  mem_arbiter_if.master  pmem_io
);

  localparam int unsigned MaskWidth = DataWidth / 8;

  arb_state_t           state_q, state_d;
  grant_t               last_grant_q, last_grant_d;
  logic                 read_q, read_d;
  logic                 write_q, write_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [MaskWidth-1:0] wmask_q, wmask_d;

  logic pend_a, pend_b;
  logic grant_a, grant_b;

  assign pend_a  = port_a_io.read | port_a_io.write;
  assign pend_b  = port_b_io.read | port_b_io.write;
  // Under contention the port that did not win last time goes next.
  assign grant_a = pend_a & (~pend_b | (last_grant_q == GrantB));
  assign grant_b = pend_b & ~grant_a;

  // Next-state: grant from IDLE, hold the latched transaction until pmem resp.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    read_d       = read_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    unique case (state_q)
      StIdle: begin
        if (grant_a) begin
          state_d      = StServeA;
          last_grant_d = GrantA;
          // Simultaneous read and write is treated as a write.
          write_d      = port_a_io.write;
          read_d       = port_a_io.read & ~port_a_io.write;
          addr_d       = port_a_io.address;
          wdata_d      = port_a_io.wdata;
          wmask_d      = port_a_io.wmask;
        end else if (grant_b) begin
          state_d      = StServeB;
          last_grant_d = GrantB;
          write_d      = port_b_io.write;
          read_d       = port_b_io.read & ~port_b_io.write;
          addr_d       = port_b_io.address;
          wdata_d      = port_b_io.wdata;
          wmask_d      = port_b_io.wmask;
        end
      end
      StServeA, StServeB: begin
        // Always return to IDLE after a response; no direct handoff.
        if (pmem_io.resp) begin
          state_d = StIdle;
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  // State and transaction registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= GrantB;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      read_q       <= read_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
    end
  end

  // Downstream port is driven only from the latched copy.
  assign pmem_io.read    = read_q;
  assign pmem_io.write   = write_q;
  assign pmem_io.address = addr_q;
  assign pmem_io.wdata   = wdata_q;
  assign pmem_io.wmask   = wmask_q;

  // Responses are steered by state; a stray resp in IDLE reaches nobody.
  assign port_a_io.resp  = pmem_io.resp & (state_q == StServeA);
  assign port_b_io.resp  = pmem_io.resp & (state_q == StServeB);
  assign port_a_io.rdata = pmem_io.rdata;
  assign port_b_io.rdata = pmem_io.rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a scoreboard of expected transactions.
module tb_mem_arbiter;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic reset;

  mem_arbiter_if #(.AddrWidth(16), .DataWidth(16)) a_if ();
  mem_arbiter_if #(.AddrWidth(16), .DataWidth(16)) b_if ();
  mem_arbiter_if #(.AddrWidth(16), .DataWidth(16)) pmem_if ();

  mem_arbiter #(.AddrWidth(16), .DataWidth(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .port_a_io (a_if),
    .port_b_io (b_if),
    .pmem_io   (pmem_if)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        port_b;
    logic        write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  wmask;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic pb, input logic w, input logic [15:0] a,
                      input logic [15:0] d, input logic [1:0] m);
    exp_t e;
    e.port_b = pb;
    e.write  = w;
    e.addr   = a;
    e.wdata  = d;
    e.wmask  = m;
    sb.push_back(e);
  endtask

  // Wait for a downstream strobe, check it against the scoreboard, answer
  // on the lat-th strobe cycle, then check the mandatory IDLE cycle.
  task automatic serve(input int lat, input logic [15:0] rd, input int exp_wait);
    exp_t e;
    int   waited = 0;
    while (!(pmem_if.read | pmem_if.write) && waited < 20) begin
      step();
      waited++;
    end
    chk("grant_wait", 32'(waited), 32'(exp_wait));
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    for (int c = 1; c <= lat; c++) begin
      if (c == lat) begin
        pmem_if.resp  = 1'b1;
        pmem_if.rdata = rd;
        #1;
      end
      chk("pmem_write", 32'(pmem_if.write), 32'(e.write));
      chk("pmem_read", 32'(pmem_if.read), 32'(!e.write));
      chk("pmem_address", 32'(pmem_if.address), 32'(e.addr));
      chk("pmem_wdata", 32'(pmem_if.wdata), 32'(e.wdata));
      chk("pmem_wmask", 32'(pmem_if.wmask), 32'(e.wmask));
      chk("resp_a", 32'(a_if.resp), 32'((c == lat) && !e.port_b));
      chk("resp_b", 32'(b_if.resp), 32'((c == lat) && e.port_b));
      if (c == lat) begin
        chk("rdata_a", 32'(a_if.rdata), 32'(rd));
        chk("rdata_b", 32'(b_if.rdata), 32'(rd));
      end else begin
        step();
      end
    end
    step();
    pmem_if.resp  = 1'b0;
    pmem_if.rdata = 16'h0000;
    #1;
    chk("idle_read", 32'(pmem_if.read), 32'd0);
    chk("idle_write", 32'(pmem_if.write), 32'd0);
    chk("idle_resp_a", 32'(a_if.resp), 32'd0);
    chk("idle_resp_b", 32'(b_if.resp), 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    a_if.read     = 1'b0;
    a_if.write    = 1'b0;
    a_if.wmask    = 2'b00;
    a_if.address  = 16'h0000;
    a_if.wdata    = 16'h0000;
    b_if.read     = 1'b0;
    b_if.write    = 1'b0;
    b_if.wmask    = 2'b00;
    b_if.address  = 16'h0000;
    b_if.wdata    = 16'h0000;
    pmem_if.resp  = 1'b0;
    pmem_if.rdata = 16'h0000;
    step();
    step();

    // Reset values.
    chk("rst_pmem_read", 32'(pmem_if.read), 32'd0);
    chk("rst_pmem_write", 32'(pmem_if.write), 32'd0);
    chk("rst_pmem_wmask", 32'(pmem_if.wmask), 32'd0);
    chk("rst_pmem_address", 32'(pmem_if.address), 32'd0);
    chk("rst_pmem_wdata", 32'(pmem_if.wdata), 32'd0);
    chk("rst_resp_a", 32'(a_if.resp), 32'd0);
    chk("rst_resp_b", 32'(b_if.resp), 32'd0);

    // A read alone, memory answers in cycle 3.
    reset        = 1'b0;
    a_if.read    = 1'b1;
    a_if.address = 16'h1000;
    push(1'b0, 1'b0, 16'h1000, 16'h0000, 2'b00);
    serve(3, 16'hBEEF, 1);
    a_if.read = 1'b0;

    // A and B together right after reset: A first, then B.
    reset = 1'b1;
    step();
    reset        = 1'b0;
    a_if.read    = 1'b1;
    a_if.address = 16'h0010;
    b_if.read    = 1'b1;
    b_if.address = 16'h0020;
    push(1'b0, 1'b0, 16'h0010, 16'h0000, 2'b00);
    push(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00);
    serve(1, 16'h1111, 1);
    a_if.read = 1'b0;
    serve(1, 16'h2222, 1);
    b_if.read = 1'b0;

    // A continuous; B write arrives mid-transaction and goes next.
    a_if.read    = 1'b1;
    a_if.address = 16'h5000;
    push(1'b0, 1'b0, 16'h5000, 16'h0000, 2'b00);
    step();
    b_if.write   = 1'b1;
    b_if.address = 16'h2002;
    b_if.wdata   = 16'h00FF;
    b_if.wmask   = 2'b01;
    push(1'b1, 1'b1, 16'h2002, 16'h00FF, 2'b01);
    serve(2, 16'h5555, 0);
    serve(1, 16'h0000, 1);
    b_if.write = 1'b0;
    b_if.wdata = 16'h0000;
    b_if.wmask = 2'b00;
    push(1'b0, 1'b0, 16'h5000, 16'h0000, 2'b00);
    serve(1, 16'h5556, 1);
    a_if.read = 1'b0;

    // B address changes while waiting; downstream holds the latched one.
    b_if.read    = 1'b1;
    b_if.address = 16'h3000;
    push(1'b1, 1'b0, 16'h3000, 16'h0000, 2'b00);
    step();
    b_if.address = 16'h4000;
    serve(3, 16'h3333, 0);
    b_if.read = 1'b0;

    // Reset during SERVE_A, then a late pmem resp.
    a_if.read    = 1'b1;
    a_if.address = 16'h6000;
    step();
    chk("pre_rst_pmem_read", 32'(pmem_if.read), 32'd1);
    reset = 1'b1;
    step();
    reset     = 1'b0;
    a_if.read = 1'b0;
    chk("abort_pmem_read", 32'(pmem_if.read), 32'd0);
    chk("abort_pmem_write", 32'(pmem_if.write), 32'd0);
    chk("abort_pmem_address", 32'(pmem_if.address), 32'd0);
    chk("abort_resp_a", 32'(a_if.resp), 32'd0);
    pmem_if.resp  = 1'b1;
    pmem_if.rdata = 16'hDEAD;
    #1;
    chk("late_resp_a", 32'(a_if.resp), 32'd0);
    chk("late_resp_b", 32'(b_if.resp), 32'd0);
    step();
    chk("late_pmem_read", 32'(pmem_if.read), 32'd0);
    pmem_if.resp  = 1'b0;
    pmem_if.rdata = 16'h0000;

    // Read and write both high: treated as a write.
    a_if.read    = 1'b1;
    a_if.write   = 1'b1;
    a_if.address = 16'h7000;
    a_if.wdata   = 16'h1234;
    a_if.wmask   = 2'b11;
    push(1'b0, 1'b1, 16'h7000, 16'h1234, 2'b11);
    serve(2, 16'h0000, 1);
    a_if.read  = 1'b0;
    a_if.write = 1'b0;
    step();
    chk("final_pmem_write", 32'(pmem_if.write), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
